// File: rtl/coherence_mem_control_pkg.sv
// Shared types for the dual-core coherence memory controller.
//   word_t      - 32-bit data/address word
//   ramstate_t  - RAM handshake state (FREE/BUSY/ACCESS/ERROR)
//   ccstate_t   - controller FSM state
//   reqclass_t  - request class chosen in IDLE, highest priority first
package coherence_mem_control_pkg;

    localparam int WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        WB         = 3'd1,
        RD         = 3'd2,
        IFETCH     = 3'd3,
        SNOOP      = 3'd4,
        SNOOP_RESP = 3'd5,
        C2C        = 3'd6,
        RD_SNOOPED = 3'd7
    } ccstate_t;

    typedef enum logic [2:0] {
        CLS_NONE = 3'd0,
        CLS_WB   = 3'd1,
        CLS_COH  = 3'd2,
        CLS_RD   = 3'd3,
        CLS_IF   = 3'd4
    } reqclass_t;

endpackage

// File: rtl/coherence_mem_control_rr_arbiter2.sv
// Two-requester round-robin arbiter (purely combinational).
//   req        in  [1:0]  request vector, one bit per CPU
//   last_grant in  1      CPU granted most recently
//   grant      out 1      index of the winning CPU
//   valid      out 1      at least one request present
module rr_arbiter2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       grant,
    output logic       valid
);

    // A sole requester always wins; on contention the CPU that did not
    // win last time gets the grant.
    always_comb begin
        valid = |req;
        if (req == 2'b11) begin
            grant = ~last_grant;
        end else begin
            grant = req[1];
        end
    end

endmodule

// File: rtl/coherence_mem_control.sv
// Bus-side coherence/memory controller for the dual-core design.
// Arbitrates icache/dcache requests of both CPUs onto the single RAM port
// and runs MSI snoops between the two dcaches, including cache-to-cache
// transfer with a concurrent RAM writeback.
//
// Ports:
//   CLK, RST                clock, async active-high reset
//   iREN, dREN, dWEN        per-CPU cache requests
//   iaddr, daddr, dstore    per-CPU request address / write data
//   ccwrite, cctrans        per-CPU coherence intent / snoop response
//   ramload, ramstate       RAM read data and handshake state
//   iwait, dwait            per-CPU stall (active high)
//   iload, dload            per-CPU read data
//   ccwait, ccinv           snoop hold / invalidate to the snooped dcache
//   ccsnoopaddr             per-CPU snoop address
//   ramREN, ramWEN          RAM enables
//   ramaddr, ramstore       RAM address / write data
//
// state      | meaning
// -----------+---------------------------------------------------------
// IDLE       | no transaction; pick class, then CPU round-robin
// WB         | plain dcache writeback of CPU g
// RD         | plain dcache read of CPU g
// IFETCH     | icache fetch of CPU g
// SNOOP      | snoop CPU o with the requester's address (1 cycle)
// SNOOP_RESP | sample CPU o's response (1 cycle)
// C2C        | o supplies data to g while it is written back to RAM
// RD_SNOOPED | RAM read for g while o is still held
module coherence_mem_control
    import coherence_mem_control_pkg::*;
#(
    parameter int CPUS = 2
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [CPUS-1:0]      iREN,
    input  logic [CPUS-1:0]      dREN,
    input  logic [CPUS-1:0]      dWEN,
    input  word_t [CPUS-1:0]     iaddr,
    input  word_t [CPUS-1:0]     daddr,
    input  word_t [CPUS-1:0]     dstore,
    input  logic [CPUS-1:0]      ccwrite,
    input  logic [CPUS-1:0]      cctrans,
    input  word_t                ramload,
    input  ramstate_t            ramstate,
    output logic [CPUS-1:0]      iwait,
    output logic [CPUS-1:0]      dwait,
    output word_t [CPUS-1:0]     iload,
    output word_t [CPUS-1:0]     dload,
    output logic [CPUS-1:0]      ccwait,
    output logic [CPUS-1:0]      ccinv,
    output word_t [CPUS-1:0]     ccsnoopaddr,
    output logic                 ramREN,
    output logic                 ramWEN,
    output word_t                ramaddr,
    output word_t                ramstore
);

    if (CPUS != 2) begin : g_bad_cpus
        $error("coherence_mem_control supports exactly 2 CPUs");
    end

    ccstate_t  state;
    ccstate_t  next_state;
    logic      last_grant;
    logic      g;
    logic      o;
    reqclass_t cls;
    logic [1:0] sel_req;
    logic      arb_grant;
    logic      arb_valid;

    // The CPU owning the current transaction is always the one granted
    // last, so last_grant doubles as the registered grant.
    assign g = last_grant;
    assign o = ~last_grant;

    always_comb begin
        cls     = CLS_NONE;
        sel_req = 2'b00;
        if (|(dWEN & ~cctrans)) begin
            cls     = CLS_WB;
            sel_req = dWEN & ~cctrans;
        end else if (|cctrans) begin
            cls     = CLS_COH;
            sel_req = cctrans;
        end else if (|(dREN & ~cctrans)) begin
            cls     = CLS_RD;
            sel_req = dREN & ~cctrans;
        end else if (|iREN) begin
            cls     = CLS_IF;
            sel_req = iREN;
        end
    end

    rr_arbiter2 u_arb (
        .req        (sel_req),
        .last_grant (last_grant),
        .grant      (arb_grant),
        .valid      (arb_valid)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= IDLE;
            last_grant <= 1'b0;
        end else begin
            state <= next_state;
            if (state == IDLE && arb_valid) begin
                last_grant <= arb_grant;
            end
        end
    end

    always_comb begin
        next_state  = state;
        iwait       = '1;
        dwait       = '1;
        iload       = '0;
        dload       = '0;
        ccwait      = '0;
        ccinv       = '0;
        ccsnoopaddr = '0;
        ramREN      = 1'b0;
        ramWEN      = 1'b0;
        ramaddr     = '0;
        ramstore    = '0;

        case (state)
            IDLE: begin
                if (arb_valid) begin
                    case (cls)
                        CLS_WB:  next_state = WB;
                        CLS_COH: next_state = SNOOP;
                        CLS_RD:  next_state = RD;
                        CLS_IF:  next_state = IFETCH;
                        default: next_state = IDLE;
                    endcase
                end
            end

            WB: begin
                ramWEN   = 1'b1;
                ramaddr  = daddr[g];
                ramstore = dstore[g];
                if (ramstate == ACCESS) begin
                    dwait[g]   = 1'b0;
                    next_state = IDLE;
                end
            end

            RD, RD_SNOOPED: begin
                ramREN  = 1'b1;
                ramaddr = daddr[g];
                if (state == RD_SNOOPED) begin
                    ccwait[o] = 1'b1;
                end
                if (ramstate == ACCESS) begin
                    dload[g]   = ramload;
                    dwait[g]   = 1'b0;
                    next_state = IDLE;
                end
            end

            IFETCH: begin
                ramREN  = 1'b1;
                ramaddr = iaddr[g];
                if (ramstate == ACCESS) begin
                    iload[g]   = ramload;
                    iwait[g]   = 1'b0;
                    next_state = IDLE;
                end
            end

            SNOOP: begin
                ccwait[o]      = 1'b1;
                ccsnoopaddr[o] = daddr[g];
                ccinv[o]       = ccwrite[g];
                next_state     = SNOOP_RESP;
            end

            SNOOP_RESP: begin
                ccwait[o]      = 1'b1;
                ccsnoopaddr[o] = daddr[g];
                ccinv[o]       = ccwrite[g];
                if (cctrans[o] && dWEN[o]) begin
                    next_state = C2C;
                end else if (dREN[g]) begin
                    next_state = RD_SNOOPED;
                end else begin
                    // S->M upgrade: invalidation alone completes it.
                    dwait[g]   = 1'b0;
                    next_state = IDLE;
                end
            end

            C2C: begin
                // Modified line goes to the requester and to RAM at once.
                ccwait[o] = 1'b1;
                ramWEN    = 1'b1;
                ramaddr   = daddr[g];
                ramstore  = dstore[o];
                dload[g]  = dstore[o];
                if (ramstate == ACCESS) begin
                    dwait[g]   = 1'b0;
                    dwait[o]   = 1'b0;
                    next_state = IDLE;
                end
            end

            default: next_state = IDLE;
        endcase
    end

endmodule

// File: tb/tb_coherence_mem_control.sv
// Self-checking bench for coherence_mem_control: a RAM model with
// programmable BUSY/ERROR latency, and scoreboard queues of expected
// completions and RAM writes compared when the DUT produces them.
module tb_coherence_mem_control;
    import coherence_mem_control_pkg::*;

    localparam word_t KEY = 32'hA5A5_0000;

    logic        CLK;
    logic        RST;
    logic [1:0]  iREN, dREN, dWEN, ccwrite, cctrans;
    word_t [1:0] iaddr, daddr, dstore;
    word_t       ramload;
    ramstate_t   ramstate;
    logic [1:0]  iwait, dwait, ccwait, ccinv;
    word_t [1:0] iload, dload, ccsnoopaddr;
    logic        ramREN, ramWEN;
    word_t       ramaddr, ramstore;

    coherence_mem_control #(.CPUS(2)) dut (
        .CLK(CLK), .RST(RST),
        .iREN(iREN), .dREN(dREN), .dWEN(dWEN),
        .iaddr(iaddr), .daddr(daddr), .dstore(dstore),
        .ccwrite(ccwrite), .cctrans(cctrans),
        .ramload(ramload), .ramstate(ramstate),
        .iwait(iwait), .dwait(dwait), .iload(iload), .dload(dload),
        .ccwait(ccwait), .ccinv(ccinv), .ccsnoopaddr(ccsnoopaddr),
        .ramREN(ramREN), .ramWEN(ramWEN),
        .ramaddr(ramaddr), .ramstore(ramstore)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // RAM model: ACCESS after ram_lat hold cycles of ram_hold state.
    int        ram_lat  = 0;
    ramstate_t ram_hold = BUSY;
    int        ram_cnt  = 0;

    always @(posedge CLK) begin
        if (!(ramREN || ramWEN) || ramstate == ACCESS) ram_cnt <= 0;
        else ram_cnt <= ram_cnt + 1;
    end

    always_comb begin
        if (ramREN || ramWEN) ramstate = (ram_cnt >= ram_lat) ? ACCESS : ram_hold;
        else ramstate = FREE;
        ramload = ramREN ? (ramaddr ^ KEY) : '0;
    end

    typedef struct {
        logic [1:0] iw;
        logic [1:0] dw;
        int         cpu;
        logic       is_i;
        logic       has_data;
        word_t      data;
    } done_t;

    typedef struct {
        word_t addr;
        word_t data;
    } wr_t;

    done_t done_q[$];
    wr_t   wr_q[$];
    int    done_cnt = 0;
    int    wen_cycles = 0;
    int    ram_en_cycles = 0;
    int    inv0_cycles = 0;

    always @(negedge CLK) begin
        if (!RST) begin
            if (ramWEN) wen_cycles++;
            if (ramREN || ramWEN) ram_en_cycles++;
            if (ccinv[0]) inv0_cycles++;
            if (ramWEN && ramstate == ACCESS) begin
                chk("wr_expected", wr_q.size() > 0, 1'b1);
                if (wr_q.size() > 0) begin
                    wr_t w;
                    w = wr_q.pop_front();
                    chk("ramaddr", ramaddr, w.addr);
                    chk("ramstore", ramstore, w.data);
                end
            end
            if (iwait != 2'b11 || dwait != 2'b11) begin
                done_cnt++;
                chk("done_expected", done_q.size() > 0, 1'b1);
                if (done_q.size() > 0) begin
                    done_t e;
                    e = done_q.pop_front();
                    chk("iwait", iwait, e.iw);
                    chk("dwait", dwait, e.dw);
                    if (e.has_data) begin
                        if (e.is_i) chk("iload", iload[e.cpu], e.data);
                        else chk("dload", dload[e.cpu], e.data);
                    end
                end
            end
        end
    end

    task automatic push_done(input logic [1:0] iw, input logic [1:0] dw, input int cpu,
                             input logic is_i, input logic has_data, input word_t data);
        done_t e;
        e.iw = iw; e.dw = dw; e.cpu = cpu; e.is_i = is_i;
        e.has_data = has_data; e.data = data;
        done_q.push_back(e);
    endtask

    task automatic push_wr(input word_t addr, input word_t data);
        wr_t w;
        w.addr = addr; w.data = data;
        wr_q.push_back(w);
    endtask

    task automatic wait_done(input int n);
        int tgt;
        int cyc;
        tgt = done_cnt + n;
        cyc = 0;
        while (done_cnt < tgt && cyc < 60) begin
            @(negedge CLK); #2;
            cyc++;
        end
        chk("done_timeout", done_cnt, tgt);
    endtask

    task automatic clear_inputs();
        iREN = '0; dREN = '0; dWEN = '0; ccwrite = '0; cctrans = '0;
    endtask

    task automatic do_rr_ifetch();
        ram_lat = 0;
        push_done(2'b01, 2'b11, 1, 1'b1, 1'b1, 32'h0000_1111 ^ KEY);
        push_done(2'b10, 2'b11, 0, 1'b1, 1'b1, 32'h0000_2222 ^ KEY);
        @(posedge CLK); #1;
        iaddr[0] = 32'h0000_2222;
        iaddr[1] = 32'h0000_1111;
        iREN = 2'b11;
        wait_done(2);
        @(posedge CLK); #1;
        clear_inputs();
    endtask

    task automatic wait_snoop(input int s);
        int cyc;
        cyc = 0;
        while (!ccwait[s] && cyc < 10) begin
            @(negedge CLK); #2;
            cyc++;
        end
        chk("snoop_seen", ccwait[s], 1'b1);
    endtask

    initial begin
        RST = 1'b1;
        clear_inputs();
        iaddr = '0; daddr = '0; dstore = '0;
        repeat (3) @(posedge CLK);
        @(negedge CLK); RST = 1'b0;
        @(negedge CLK); #2;

        // idle outputs after reset
        chk("rst_iwait", iwait, 2'b11);
        chk("rst_dwait", dwait, 2'b11);
        chk("rst_ccwait", ccwait, 2'b00);
        chk("rst_ccinv", ccinv, 2'b00);
        chk("rst_ram_en", {ramREN, ramWEN}, 2'b00);
        chk("rst_ramaddr", ramaddr, 32'h0);
        chk("rst_ramstore", ramstore, 32'h0);
        chk("rst_snoopaddr", ccsnoopaddr, 64'h0);
        chk("rst_loads", {iload, dload} != 0, 1'b0);

        // round robin from last_grant=0: CPU1 first
        do_rr_ifetch();

        // plain writeback with two BUSY cycles
        ram_lat = 2; ram_hold = BUSY;
        push_wr(32'h100, 32'hDEAD);
        push_done(2'b11, 2'b10, 0, 1'b0, 1'b0, '0);
        @(posedge CLK); #1;
        wen_cycles = 0;
        daddr[0] = 32'h100; dstore[0] = 32'hDEAD; dWEN = 2'b01;
        wait_done(1);
        @(posedge CLK); #1;
        clear_inputs();
        @(negedge CLK); #2;
        chk("wb_wen_cycles", wen_cycles, 3);

        // class priority: CPU1 writeback before CPU0 ifetch
        ram_lat = 1;
        push_wr(32'h140, 32'h0000_7777);
        push_done(2'b11, 2'b01, 1, 1'b0, 1'b0, '0);
        push_done(2'b10, 2'b11, 0, 1'b1, 1'b1, 32'h0000_3300 ^ KEY);
        @(posedge CLK); #1;
        iaddr[0] = 32'h0000_3300; iREN = 2'b01;
        daddr[1] = 32'h140; dstore[1] = 32'h0000_7777; dWEN = 2'b10;
        wait_done(1);
        @(posedge CLK); #1;
        dWEN = 2'b00;
        wait_done(1);
        @(posedge CLK); #1;
        clear_inputs();

        // read held by ERROR cycles
        ram_lat = 2; ram_hold = ERROR;
        push_done(2'b11, 2'b01, 1, 1'b0, 1'b1, 32'h300 ^ KEY);
        @(posedge CLK); #1;
        daddr[1] = 32'h300; dREN = 2'b10;
        wait_done(1);
        @(posedge CLK); #1;
        clear_inputs();
        ram_hold = BUSY;

        // cache-to-cache: CPU0 misses, CPU1 supplies modified line
        ram_lat = 1;
        push_wr(32'h200, 32'hBEEF);
        push_done(2'b11, 2'b00, 0, 1'b0, 1'b1, 32'hBEEF);
        @(posedge CLK); #1;
        daddr[0] = 32'h200; dstore[0] = 32'h5555;
        dREN = 2'b01; cctrans = 2'b01; ccwrite = 2'b01;
        wait_snoop(1);
        chk("c2c_ccinv1", ccinv[1], 1'b1);
        chk("c2c_snoopaddr1", ccsnoopaddr[1], 32'h200);
        @(posedge CLK); #1;
        cctrans[1] = 1'b1; dWEN[1] = 1'b1; dstore[1] = 32'hBEEF;
        wait_done(1);
        @(posedge CLK); #1;
        clear_inputs();
        @(negedge CLK); #2;
        chk("c2c_ccwait_release", ccwait, 2'b00);

        // S->M upgrade by CPU1: invalidate only, no RAM traffic
        push_done(2'b11, 2'b01, 1, 1'b0, 1'b0, '0);
        @(posedge CLK); #1;
        inv0_cycles = 0; ram_en_cycles = 0;
        daddr[1] = 32'h240; cctrans = 2'b10; ccwrite = 2'b10;
        wait_done(1);
        @(posedge CLK); #1;
        clear_inputs();
        @(negedge CLK); #2;
        chk("upg_inv0_cycles", inv0_cycles, 2);
        chk("upg_ram_en", ram_en_cycles, 0);

        // reset in the middle of a C2C owned by CPU1
        ram_lat = 20;
        @(posedge CLK); #1;
        daddr[1] = 32'h280; dREN = 2'b10; cctrans = 2'b10; ccwrite = 2'b10;
        wait_snoop(0);
        @(posedge CLK); #1;
        cctrans[0] = 1'b1; dWEN[0] = 1'b1; dstore[0] = 32'hCAFE;
        begin
            int cyc;
            cyc = 0;
            while (!ramWEN && cyc < 10) begin
                @(negedge CLK); #2;
                cyc++;
            end
        end
        chk("c2c_reached", ramWEN, 1'b1);
        #1 RST = 1'b1;
        #1;
        chk("mid_rst_iwait", iwait, 2'b11);
        chk("mid_rst_dwait", dwait, 2'b11);
        chk("mid_rst_ccwait", ccwait, 2'b00);
        chk("mid_rst_ramwen", ramWEN, 1'b0);
        @(posedge CLK); #1;
        clear_inputs();
        @(negedge CLK); RST = 1'b0;
        ram_lat = 0;

        // last_grant back at 0: CPU1 wins first again
        do_rr_ifetch();

        repeat (2) @(negedge CLK);
        chk("done_q_empty", done_q.size(), 0);
        chk("wr_q_empty", wr_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, limit %0d ns", 100000);
        $fatal(1, "watchdog");
    end

endmodule
